// File: rtl/tile_dispatch.sv
// tile_dispatch: walks the tile-aligned bounding box of one triangle at a time,
// issuing one raster transaction per covered tile with a fixed gap between tiles.
module tile_dispatch #(
    parameter int TILE_WIDTH   = 32,
    parameter int TILE_COLUMNS = 20,
    parameter int TILE_ROWS    = 15,
    parameter int TILE_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_vld_in,
    output logic        tri_rdy_out,
    input  logic [27:0] v0_in,
    input  logic [27:0] v1_in,
    input  logic [27:0] v2_in,
    input  logic [3:0]  color_in,
    output logic        ras_vld_out,
    input  logic        ras_rdy_in,
    output logic [27:0] ras_v0,
    output logic [27:0] ras_v1,
    output logic [27:0] ras_v2,
    output logic [15:0] ras_metadata,
    output logic        tri_done,
    output logic        busy,
    output logic [15:0] tiles_issued
);
    localparam int SHIFT = $clog2(TILE_WIDTH);
    localparam int CW    = $clog2(TILE_CYCLES + 1);
    localparam logic [4:0]    X_LAST   = 5'(TILE_COLUMNS - 1);
    localparam logic [4:0]    Y_LAST   = 5'(TILE_ROWS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TILE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BBOX  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    logic [3:0]      color_r;
    logic [4:0]      x_min_r;
    logic [4:0]      x_max_r;
    logic [4:0]      y_max_r;
    logic [4:0]      cur_x_r;
    logic [4:0]      cur_y_r;
    logic [CW-1:0]   wait_cnt_r;

    logic [4:0]      bx_min_s;
    logic [4:0]      bx_max_s;
    logic [4:0]      by_min_s;
    logic [4:0]      by_max_s;
    logic [4:0]      bx_raw_s;
    logic [4:0]      by_raw_s;
    logic            off_grid_s;
    logic            last_tile_s;
    logic [4:0]      nxt_x_s;
    logic [4:0]      nxt_y_s;

    function automatic logic [4:0] tile_of(input logic [9:0] c);
        logic [9:0] t;
        t = c >> SHIFT;
        return t[4:0];
    endfunction

    function automatic logic [4:0] min3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        logic [4:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [4:0] max3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        logic [4:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [15:0] pack_meta(input logic [3:0] col, input logic [3:0] ty, input logic [4:0] tx);
        return {col, 3'b000, ty, tx};
    endfunction

    // Bounding box of the captured triangle and next tile in row-major order
    always_comb begin
        bx_min_s    = min3(tile_of(ras_v0[27:18]), tile_of(ras_v1[27:18]), tile_of(ras_v2[27:18]));
        by_min_s    = min3(tile_of(ras_v0[17:8]),  tile_of(ras_v1[17:8]),  tile_of(ras_v2[17:8]));
        bx_raw_s    = max3(tile_of(ras_v0[27:18]), tile_of(ras_v1[27:18]), tile_of(ras_v2[27:18]));
        by_raw_s    = max3(tile_of(ras_v0[17:8]),  tile_of(ras_v1[17:8]),  tile_of(ras_v2[17:8]));
        bx_max_s    = (bx_raw_s > X_LAST) ? X_LAST : bx_raw_s;
        by_max_s    = (by_raw_s > Y_LAST) ? Y_LAST : by_raw_s;
        off_grid_s  = (bx_min_s > X_LAST) || (by_min_s > Y_LAST);
        last_tile_s = (cur_x_r == x_max_r) && (cur_y_r == y_max_r);
        nxt_x_s     = cur_x_r;
        nxt_y_s     = cur_y_r;
        if (cur_x_r == x_max_r) begin
            nxt_x_s = x_min_r;
            nxt_y_s = cur_y_r + 5'd1;
        end else begin
            nxt_x_s = cur_x_r + 5'd1;
            nxt_y_s = cur_y_r;
        end
    end

    // Dispatcher FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            tri_rdy_out  <= 1'b0;
            ras_vld_out  <= 1'b0;
            tri_done     <= 1'b0;
            busy         <= 1'b0;
            tiles_issued <= 16'd0;
            wait_cnt_r   <= '0;
            ras_v0       <= 28'd0;
            ras_v1       <= 28'd0;
            ras_v2       <= 28'd0;
            ras_metadata <= 16'd0;
            color_r      <= 4'd0;
            x_min_r      <= 5'd0;
            x_max_r      <= 5'd0;
            y_max_r      <= 5'd0;
            cur_x_r      <= 5'd0;
            cur_y_r      <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    tri_done <= 1'b0;
                    if (tri_vld_in && tri_rdy_out) begin
                        ras_v0      <= v0_in;
                        ras_v1      <= v1_in;
                        ras_v2      <= v2_in;
                        color_r     <= color_in;
                        tri_rdy_out <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= BBOX;
                    end else begin
                        tri_rdy_out <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                BBOX: begin
                    x_min_r <= bx_min_s;
                    x_max_r <= bx_max_s;
                    y_max_r <= by_max_s;
                    if (off_grid_s) begin
                        tri_done <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        cur_x_r      <= bx_min_s;
                        cur_y_r      <= by_min_s;
                        ras_metadata <= pack_meta(color_r, by_min_s[3:0], bx_min_s);
                        ras_vld_out  <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ras_rdy_in) begin
                        ras_vld_out  <= 1'b0;
                        tiles_issued <= tiles_issued + 16'd1;
                        wait_cnt_r   <= CNT_LOAD;
                        state_r      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r != '0) begin
                        wait_cnt_r <= wait_cnt_r - CNT_ONE;
                    end else if (last_tile_s) begin
                        tri_done <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        cur_x_r      <= nxt_x_s;
                        cur_y_r      <= nxt_y_s;
                        ras_metadata <= pack_meta(color_r, nxt_y_s[3:0], nxt_x_s);
                        ras_vld_out  <= 1'b1;
                        state_r      <= ISSUE;
                    end
                end
                DONE: begin
                    tri_done    <= 1'b0;
                    tri_rdy_out <= 1'b1;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    tri_rdy_out <= 1'b0;
                    ras_vld_out <= 1'b0;
                    tri_done    <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_dispatch.sv
// Bench for tile_dispatch: directed vector table, reset-abort sequence and
// randomized triangles checked against a bounding-box tile-list model.
module tb_tile_dispatch;
    localparam int TC   = 16;
    localparam int TW   = 32;
    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_vld_in;
    logic        tri_rdy_out;
    logic [27:0] v0_in, v1_in, v2_in;
    logic [3:0]  color_in;
    logic        ras_vld_out;
    logic        ras_rdy_in;
    logic [27:0] ras_v0, ras_v1, ras_v2;
    logic [15:0] ras_metadata;
    logic        tri_done;
    logic        busy;
    logic [15:0] tiles_issued;

    int          tests  = 0;
    int          failed = 0;
    logic [15:0] exp_issued = 16'd0;
    logic [15:0] exp_q[$];

    tile_dispatch #(.TILE_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .tri_vld_in(tri_vld_in), .tri_rdy_out(tri_rdy_out),
        .v0_in(v0_in), .v1_in(v1_in), .v2_in(v2_in), .color_in(color_in),
        .ras_vld_out(ras_vld_out), .ras_rdy_in(ras_rdy_in),
        .ras_v0(ras_v0), .ras_v1(ras_v1), .ras_v2(ras_v2),
        .ras_metadata(ras_metadata), .tri_done(tri_done),
        .busy(busy), .tiles_issued(tiles_issued)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [27:0] v0, v1, v2;
        logic [3:0]  col;
        int          n_tiles;
        logic [15:0] first_md;
        logic [15:0] last_md;
        int          bp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] mkv(input int x, input int y, input int z);
        return {10'(x), 10'(y), 8'(z)};
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Expected tile list: clamped bounding box enumerated row-major
    function automatic void build_model(input logic [27:0] a, input logic [27:0] b,
                                        input logic [27:0] c, input logic [3:0] col);
        int lo_x, hi_x, lo_y, hi_y;
        exp_q.delete();
        lo_x = min3(int'(a[27:18]) / TW, int'(b[27:18]) / TW, int'(c[27:18]) / TW);
        hi_x = max3(int'(a[27:18]) / TW, int'(b[27:18]) / TW, int'(c[27:18]) / TW);
        lo_y = min3(int'(a[17:8]) / TW, int'(b[17:8]) / TW, int'(c[17:8]) / TW);
        hi_y = max3(int'(a[17:8]) / TW, int'(b[17:8]) / TW, int'(c[17:8]) / TW);
        if (lo_x >= COLS || lo_y >= ROWS) return;
        if (hi_x >= COLS) hi_x = COLS - 1;
        if (hi_y >= ROWS) hi_y = ROWS - 1;
        for (int ty = lo_y; ty <= hi_y; ty++)
            for (int tx = lo_x; tx <= hi_x; tx++)
                exp_q.push_back({col, 3'b000, 4'(ty), 5'(tx)});
    endfunction

    task automatic run_tri(input logic [27:0] a, input logic [27:0] b, input logic [27:0] c,
                           input logic [3:0] col, input int bp, input bit rnd,
                           output int n_seen, output logic [15:0] first_md, output logic [15:0] last_md);
        int cyc, next_evt, idx, held, n, limit;
        bit done_seen, r;
        build_model(a, b, c, col);
        n = exp_q.size();
        n_seen = 0; first_md = 16'hFFFF; last_md = 16'hFFFF;
        held = 0; idx = 0; done_seen = 1'b0;
        ras_rdy_in = 1'b0;
        for (int i = 0; i < 8 && !tri_rdy_out; i++) step();
        chk("tri_rdy_idle", tri_rdy_out, 84'd1);
        tri_vld_in = 1'b1; v0_in = a; v1_in = b; v2_in = c; color_in = col;
        step();
        tri_vld_in = 1'b0;
        v0_in = 28'($urandom()); v1_in = 28'($urandom()); v2_in = 28'($urandom());
        color_in = 4'($urandom());
        chk("busy_bbox", {busy, tri_rdy_out}, 84'b10);
        cyc = 1; next_evt = 2;
        limit = 40 + bp + (n + 1) * (TC + 1) * 4;
        while (!done_seen && cyc < limit) begin
            if (idx < n && cyc >= next_evt) begin
                chk("issue_vld", ras_vld_out, 84'd1);
                chk("issue_meta", ras_metadata, exp_q[idx]);
                chk("issue_verts", {ras_v0, ras_v1, ras_v2}, {a, b, c});
                if (idx == 0 && held < bp) begin
                    r = 1'b0; held++;
                end else if (rnd) begin
                    r = ($urandom_range(0, 2) != 0);
                end else begin
                    r = 1'b1;
                end
                ras_rdy_in = r;
                if (r) begin
                    if (n_seen == 0) first_md = ras_metadata;
                    last_md = ras_metadata;
                    n_seen++; idx++;
                    exp_issued = exp_issued + 16'd1;
                    next_evt = cyc + TC + 1;
                end
            end else if (idx == n && cyc >= next_evt) begin
                chk("done_pulse", {tri_done, ras_vld_out}, 84'b10);
                done_seen = 1'b1;
                ras_rdy_in = 1'($urandom());
            end else begin
                chk("quiet", {tri_done, ras_vld_out}, 84'b00);
                ras_rdy_in = 1'($urandom());
            end
            step();
            cyc++;
            chk("tiles_issued", tiles_issued, exp_issued);
        end
        if (!done_seen) begin
            tests++; failed++;
            $display("FAIL done_timeout: no tri_done within %0d cycles", limit);
        end
        chk("idle_after_done", {tri_rdy_out, busy, tri_done}, 84'b100);
    endtask

    initial begin
        vec_t vecs[8];
        int n_seen, bad;
        logic [15:0] fmd, lmd;
        logic [27:0] a, b, c;
        int bx, by;

        vecs[0] = '{mkv(10,10,1),    mkv(20,10,2),    mkv(10,20,3),    4'h5, 1, 16'h5000, 16'h5000, 0};
        vecs[1] = '{mkv(30,30,0),    mkv(40,30,0),    mkv(30,40,0),    4'hA, 4, 16'hA000, 16'hA021, 0};
        vecs[2] = '{mkv(630,470,9),  mkv(1023,470,9), mkv(630,1023,9), 4'h3, 1, 16'h31D3, 16'h31D3, 0};
        vecs[3] = '{mkv(640,0,0),    mkv(700,100,0),  mkv(1023,50,0),  4'h7, 0, 16'hFFFF, 16'hFFFF, 0};
        vecs[4] = '{mkv(100,100,4),  mkv(110,105,5),  mkv(120,120,6),  4'h9, 1, 16'h9063, 16'h9063, 7};
        vecs[5] = '{mkv(0,0,0),      mkv(95,0,0),     mkv(0,63,0),     4'h1, 6, 16'h1000, 16'h1022, 0};
        vecs[6] = '{mkv(0,480,0),    mkv(10,500,0),   mkv(20,600,0),   4'h2, 0, 16'hFFFF, 16'hFFFF, 0};
        vecs[7] = '{mkv(639,479,0),  mkv(639,479,0),  mkv(639,479,0),  4'hF, 1, 16'hF1D3, 16'hF1D3, 0};

        rst = 1'b1; tri_vld_in = 1'b0; ras_rdy_in = 1'b0;
        v0_in = 28'd0; v1_in = 28'd0; v2_in = 28'd0; color_in = 4'd0;
        step(); step();
        chk("reset_ctrl", {tri_rdy_out, ras_vld_out, tri_done, busy}, 84'b0000);
        chk("reset_cnt", tiles_issued, 84'd0);
        chk("reset_data", {ras_metadata, ras_v0}, 84'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_tri(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].col, vecs[i].bp, 1'b0, n_seen, fmd, lmd);
            chk($sformatf("vec%0d_count", i), n_seen, vecs[i].n_tiles);
            chk($sformatf("vec%0d_first", i), fmd, vecs[i].first_md);
            chk($sformatf("vec%0d_last", i), lmd, vecs[i].last_md);
        end

        // Reset while waiting between tiles of a 2x2 triangle
        for (int i = 0; i < 8 && !tri_rdy_out; i++) step();
        tri_vld_in = 1'b1; v0_in = mkv(30,30,0); v1_in = mkv(40,30,0); v2_in = mkv(30,40,0); color_in = 4'hA;
        step();
        tri_vld_in = 1'b0; ras_rdy_in = 1'b1;
        step();
        chk("rst_case_issue", {ras_vld_out, ras_metadata}, {1'b1, 16'hA000});
        step(); step(); step();
        exp_issued = exp_issued + 16'd1;
        chk("rst_case_cnt", tiles_issued, exp_issued);
        chk("rst_case_wait", {ras_vld_out, busy}, 84'b01);
        rst = 1'b1;
        step();
        exp_issued = 16'd0;
        chk("rst_abort_ctrl", {ras_vld_out, busy, tri_rdy_out, tri_done}, 84'b0000);
        chk("rst_abort_cnt", tiles_issued, exp_issued);
        rst = 1'b0;
        step();
        chk("rst_rdy_after", tri_rdy_out, 84'd1);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (ras_vld_out !== 1'b0 || tiles_issued !== 16'd0) bad++;
            step();
        end
        chk("rst_no_more_tiles", bad, 84'd0);

        for (int t = 0; t < 25; t++) begin
            bx = $urandom_range(0, 1023);
            by = $urandom_range(0, 700);
            a = mkv((bx + $urandom_range(0,80)) > 1023 ? 1023 : bx + $urandom_range(0,80),
                    (by + $urandom_range(0,80)) > 1023 ? 1023 : by + $urandom_range(0,80), $urandom_range(0,255));
            b = mkv((bx + $urandom_range(0,80)) > 1023 ? 1023 : bx + $urandom_range(0,80),
                    (by + $urandom_range(0,80)) > 1023 ? 1023 : by + $urandom_range(0,80), $urandom_range(0,255));
            c = mkv((bx + $urandom_range(0,80)) > 1023 ? 1023 : bx + $urandom_range(0,80),
                    (by + $urandom_range(0,80)) > 1023 ? 1023 : by + $urandom_range(0,80), $urandom_range(0,255));
            run_tri(a, b, c, 4'($urandom()), $urandom_range(0, 3), 1'b1, n_seen, fmd, lmd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/tile_dispatch.md
Name: tile_dispatch

Overview:
- Sequences the tile rasterizer. Accepts one triangle at a time: three 28-bit screen-space vertices (x[27:18], y[17:8], z[7:0]) plus a 4-bit color.
- Computes the triangle's tile-aligned bounding box, clamped to the 20x15 grid of 32x32-pixel tiles.
- Issues one (vertices, metadata) transaction per covered tile to the raster core, row-major. After each accepted issue it waits a fixed tile-processing window before issuing the next tile.

Parameters:
- TILE_WIDTH, 32, pixels per tile edge (power of two; shift = log2).
- TILE_COLUMNS, 20, tiles per row.
- TILE_ROWS, 15, tiles per column.
- TILE_CYCLES, 1024, cycles the raster core needs per tile after accepting it.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- tri_vld_in  in  1  triangle valid.
- tri_rdy_out  out  1  dispatcher can accept a triangle.
- v0_in, v1_in, v2_in  in  28 each  triangle vertices.
- color_in  in  4  triangle color.
- ras_vld_out  out  1  tile transaction valid to raster core.
- ras_rdy_in  in  1  raster core accepts transaction.
- ras_v0, ras_v1, ras_v2  out  28 each  captured vertices, passed through unchanged.
- ras_metadata  out  16  {color[15:12], 3'b000, tile_y[8:5], tile_x[4:0]}.
- tri_done  out  1  one-cycle pulse when all tiles of the current triangle are processed.
- busy  out  1  high in any state other than IDLE.
- tiles_issued  out  16  running count of accepted tile transactions; wraps at 2^16.

Behaviour:
- The clock is named clk. The reset is named rst and is synchronous, active-high; one clock domain.
- While rst is high:
  - state = IDLE.
  - tri_rdy_out = 0, ras_vld_out = 0, tri_done = 0, busy = 0.
  - tiles_issued = 0, wait counter = 0.
  - Captured vertex/metadata registers are cleared to 0.
- Reset asserted in any state aborts the triangle in flight. No further ras_vld_out is asserted.
- FSM states: IDLE, BBOX, ISSUE, WAIT, DONE.
- IDLE:
  - tri_rdy_out = 1.
  - On tri_vld_in && tri_rdy_out, capture v0..v2 and color, then go to BBOX.
- BBOX (exactly 1 cycle):
  - tx = x >> 5 (5 bits, 0..31); ty = y >> 5 (5 bits).
  - tx_min/tx_max = min/max of the three tx values; same for ty.
  - Clamp: tx_max = min(tx_max, 19); ty_max = min(ty_max, 14).
  - If tx_min > 19 or ty_min > 14, the triangle is off-grid: go to DONE with no issues.
  - Otherwise set cur = (tx_min, ty_min) and go to ISSUE.
  - Coordinates are unsigned; vertex order and winding are ignored.
- ISSUE:
  - ras_vld_out = 1. ras_v*/ras_metadata reflect the current tile and are held stable until the handshake.
  - On ras_vld_out && ras_rdy_in: tiles_issued += 1, counter = TILE_CYCLES-1, go to WAIT.
  - ras_vld_out never drops without a handshake, except under reset.
- WAIT:
  - ras_vld_out = 0; counter decrements once per cycle.
  - When counter == 0:
    - If cur == (tx_max, ty_max), go to DONE.
    - Else if cur_x == tx_max, set cur_x = tx_min and cur_y += 1, then go to ISSUE.
    - Else cur_x += 1, then go to ISSUE.
- DONE: tri_done = 1 for exactly one cycle, then go to IDLE.
- Timing:
  - Triangle accept at cycle 0: BBOX at cycle 1; first ras_vld_out at cycle 2.
  - Tile handshake at cycle h: next ras_vld_out at h+TILE_CYCLES+1.
  - Last tile handshake at h: tri_done at h+TILE_CYCLES+1; tri_rdy_out high at h+TILE_CYCLES+2.
  - Off-grid triangle: tri_done at cycle 2, tri_rdy_out at cycle 3.
- tri_rdy_out is 0 in BBOX, ISSUE, WAIT and DONE. No triangle overlap.

Test Plan:
- Single tile: v=(10,10),(20,10),(10,20), color 5, ras_rdy_in=1, TILE_CYCLES=16 -> one transaction with metadata 0x5000 at cycle 2; tri_done at cycle 19; tiles_issued=1.
- 2x2 span: x/y spanning 30..40, color 0xA, TILE_CYCLES=16 -> metadata 0xA000, 0xA001, 0xA020, 0xA021 in that order; handshakes 17 cycles apart; tiles_issued=4.
- Clamp: v=(630,470),(1023,470),(630,1023), color 3 -> exactly one tile, metadata 0x31D3 (tile_x=19, tile_y=14).
- Off-grid: all x>=640 -> ras_vld_out never asserted; tri_done at cycle 2; tri_rdy_out=1 at cycle 3.
- Backpressure: ras_rdy_in low for 7 cycles during ISSUE -> ras_vld_out, ras_v*, ras_metadata stable all 7 cycles; WAIT starts only after the handshake; tiles_issued increments once.
- Reset in WAIT of a 2x2 triangle -> next cycle ras_vld_out=0, busy=0, tiles_issued=0; tri_rdy_out=1 the first cycle after rst drops; no further tiles issued.
